// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// arithmetic/logic/shift/compare ops; define ALU_MC_MUL_EN for the iterative multiplier.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MC_MUL_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t state, state_next;
  logic   accept;
  logic   alu_load;

  assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

`ifdef ALU_MC_MUL_EN
  localparam logic [3:0]     OP_MUL    = 4'b0011;
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  logic             mul_start;
  logic             mul_last;
  logic [WIDTH-1:0] mcand, mplier, acc, mul_final;
  logic [SHW-1:0]   iter;

  assign mul_start = accept && (control == OP_MUL);
  assign alu_load  = accept && (control != OP_MUL);
  assign mul_last  = (state == BUSY) && (iter == LAST_ITER);
  assign mul_final = acc + (mplier[0] ? mcand : '0);

  // NOTE: pure datapath registers need no reset; every mul reloads them on start.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand  <= operand_a;
      mplier <= operand_b;
      acc    <= '0;
      iter   <= '0;
    end else if (state == BUSY) begin
      acc    <= mul_final;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + SHW'(1);
    end
  end
`else
  assign alu_load = accept;
`endif

  // Single-cycle datapath: sub is a + ~b + 1 sharing the adder.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic             carry_into_msb;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;

  assign is_sub         = (control == OP_SUB);
  assign b_eff          = is_sub ? ~operand_b : operand_b;
  assign sum_ext        = {1'b0, operand_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign carry_into_msb = operand_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_ext[WIDTH-1];
  assign shamt          = operand_b[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        alu_res  = sum_ext[WIDTH-1:0];
        alu_cout = sum_ext[WIDTH];
        alu_ovf  = carry_into_msb ^ sum_ext[WIDTH];
      end
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_SLL:  alu_res = operand_a << shamt;
      OP_SRL:  alu_res = operand_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(operand_a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    if (accept) begin
`ifdef ALU_MC_MUL_EN
      state_next = (control == OP_MUL) ? BUSY : DONE;
`else
      state_next = DONE;
`endif
    end else begin
      case (state)
`ifdef ALU_MC_MUL_EN
        BUSY:    if (mul_last) state_next = DONE;
`endif
        DONE:    if (out_ready) state_next = IDLE;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (alu_load) begin
      result   <= alu_res;
      cout     <= alu_cout;
      overflow <= alu_ovf;
      zero     <= (alu_res == '0);
`ifdef ALU_MC_MUL_EN
    end else if (mul_last) begin
      result   <= mul_final;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= (mul_final == '0);
`endif
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 32-bit and an 8-bit instance, directed vectors,
// expected responses queued at accept and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_alu_mc;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_UND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1110;

  typedef struct {
    int          dut;
    string       name;
    logic [63:0] res;
    logic        c;
    logic        o;
    logic        z;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid32, in_valid8, out_ready;
  logic [63:0] op_a, op_b;
  logic [3:0]  ctrl;

  logic        ir32, ov32, c32, o32, z32;
  logic [31:0] res32;
  logic        ir8, ov8, c8, o8, z8;
  logic [7:0]  res8;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  bit   seen[2];

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(ir32),
    .operand_a(op_a[31:0]), .operand_b(op_b[31:0]), .control(ctrl),
    .out_valid(ov32), .out_ready(out_ready), .result(res32),
    .cout(c32), .overflow(o32), .zero(z32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(ir8),
    .operand_a(op_a[7:0]), .operand_b(op_b[7:0]), .control(ctrl),
    .out_valid(ov8), .out_ready(out_ready), .result(res8),
    .cout(c8), .overflow(o8), .zero(z8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic observe(input int id, input logic v, input logic r, input logic [63:0] res,
                         input logic c, input logic o, input logic z);
    exp_t e;
    if (v !== 1'b1) return;
    if (sb_q.size() == 0 || sb_q[0].dut != id) begin
      n_checks++;
      $display("FAIL unexpected_output dut%0d: got result 0x%0h with nothing expected", id, res);
      return;
    end
    e = sb_q[0];
    if (!seen[id]) begin
      check({e.name, " latency"}, 64'(cyc), 64'(e.due));
      seen[id] = 1'b1;
    end
    check({e.name, " result"}, res, e.res);
    check({e.name, " flags c/o/z"}, 64'({c, o, z}), 64'({e.c, e.o, e.z}));
    if (r === 1'b1) begin
      void'(sb_q.pop_front());
      seen[id] = 1'b0;
    end
  endtask

  always @(negedge clk) observe(0, ov32, out_ready, 64'(res32), c32, o32, z32);
  always @(negedge clk) observe(1, ov8, out_ready, 64'(res8), c8, o8, z8);

  // Drives one request, waits for acceptance, and queues the expected response.
  task automatic issue(input int id, input string name, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                       input logic c, input logic o, input logic z, input int lat, input bit push);
    bit done = 1'b0;
    op_a = a;
    op_b = b;
    ctrl = op;
    if (id == 0) in_valid32 = 1'b1;
    else         in_valid8  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (((id == 0) ? ir32 : ir8) === 1'b1) begin
        last_acc_cyc = cyc;
        if (push) sb_q.push_back('{id, name, r, c, o, z, cyc + lat});
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s timeout: in_ready never seen, required within 100 cycles", name);
    end
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    in_valid8  = 1'b0;
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 200 && !empty; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) empty = 1'b1;
    end
    if (!empty) begin
      n_checks++;
      $display("FAIL drain timeout: %0d results still pending, required 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int stray;
    rst = 1'b1;
    in_valid32 = 1'b0;
    in_valid8 = 1'b0;
    out_ready = 1'b1;
    op_a = '0;
    op_b = '0;
    ctrl = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready32", 64'(ir32), 64'd0);
    check("reset out_valid32", 64'(ov32), 64'd0);
    check("reset result32", 64'(res32), 64'd0);
    check("reset flags32", 64'({c32, o32, z32}), 64'd0);
    check("reset in_ready8", 64'(ir8), 64'd0);
    check("reset out_valid8", 64'(ov8), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle in_ready32", 64'(ir32), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops on the 32-bit instance.
    issue(0, "add_ovf",  OP_ADD,  64'h7FFFFFFF, 64'h1,        64'h80000000, 0, 1, 0, 1, 1);
    issue(0, "sub_zero", OP_SUB,  64'h5,        64'h5,        64'h0,        1, 0, 1, 1, 1);
    issue(0, "sltu",     OP_SLTU, 64'h1,        64'hFFFFFFFF, 64'h1,        0, 0, 0, 1, 1);
    issue(0, "slt",      OP_SLT,  64'h1,        64'hFFFFFFFF, 64'h0,        0, 0, 1, 1, 1);
    issue(0, "slt_neg",  OP_SLT,  64'hFFFFFFFF, 64'h1,        64'h1,        0, 0, 0, 1, 1);
    issue(0, "sra",      OP_SRA,  64'h80000000, 64'h21,       64'hC0000000, 0, 0, 0, 1, 1);
    issue(0, "srl",      OP_SRL,  64'h80000000, 64'h21,       64'h40000000, 0, 0, 0, 1, 1);
    issue(0, "sll",      OP_SLL,  64'h1,        64'h1F,       64'h80000000, 0, 0, 0, 1, 1);
    issue(0, "sll_zero", OP_SLL,  64'h12345678, 64'h20,       64'h12345678, 0, 0, 0, 1, 1);
    issue(0, "and",      OP_AND,  64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 0, 0, 0, 1, 1);
    issue(0, "or",       OP_OR,   64'hF0F0F0F0, 64'h0F0F0F0F, 64'hFFFFFFFF, 0, 0, 0, 1, 1);
    issue(0, "xor_zero", OP_XOR,  64'hAAAAAAAA, 64'hAAAAAAAA, 64'h0,        0, 0, 1, 1, 1);
    issue(0, "sub_neg",  OP_SUB,  64'h0,        64'h1,        64'hFFFFFFFF, 0, 0, 0, 1, 1);
    issue(0, "sub_ovf",  OP_SUB,  64'h80000000, 64'h1,        64'h7FFFFFFF, 1, 1, 0, 1, 1);
    issue(0, "add_wrap", OP_ADD,  64'hFFFFFFFF, 64'h1,        64'h0,        1, 0, 1, 1, 1);
    issue(0, "undef",    OP_UND,  64'h12,       64'h34,       64'h0,        0, 0, 1, 1, 1);
    drain();

    // Backpressure: result held, no accept, then accept on the release cycle.
    out_ready = 1'b0;
    issue(0, "bp_first", OP_ADD, 64'h2, 64'h3, 64'h5, 0, 0, 0, 1, 1);
    op_a = 64'h0F0F0F0F;
    op_b = 64'h00FF00FF;
    ctrl = OP_XOR;
    in_valid32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp in_ready held low", 64'(ir32), 64'd0);
      check("bp result held", 64'(res32), 64'h5);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    c0 = cyc;
    issue(0, "bp_second", OP_XOR, 64'h0F0F0F0F, 64'h00FF00FF, 64'h0FF00FF0, 0, 0, 0, 1, 1);
    check("bp same-cycle accept", 64'(last_acc_cyc), 64'(c0));
    drain();

    // Reset clears a nonzero registered result.
    rst = 1'b1;
    @(negedge clk);
    check("rst in_ready low", 64'(ir32), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst result cleared", 64'(res32), 64'd0);
    check("rst flags cleared", 64'({c32, o32, z32}), 64'd0);
    @(posedge clk);
    #1;

`ifdef ALU_MC_MUL_EN
    issue(0, "mul_big", OP_MUL, 64'h10000, 64'h10001, 64'h00010000, 0, 0, 0, 33, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy in_ready low", 64'(ir32), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(0, "mul_ones", OP_MUL, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1, 0, 0, 0, 33, 1);
    issue(0, "mul_zero", OP_MUL, 64'h1234,     64'h0,        64'h0, 0, 0, 1, 33, 1);
    issue(0, "add_after_mul", OP_ADD, 64'h7, 64'h6, 64'hD, 0, 0, 0, 1, 1);
    drain();
    // Abort a mul with rst in its tenth BUSY cycle.
    issue(0, "mul_abort", OP_MUL, 64'h7, 64'h6, 64'h2A, 0, 0, 0, 33, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort rst in_ready low", 64'(ir32), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov32 !== 1'b0) stray++;
    end
    check("abort out_valid cycles", 64'(stray), 64'd0);
    check("abort idle in_ready", 64'(ir32), 64'd1);
    @(posedge clk);
    #1;
`else
    issue(0, "op0011_undef", OP_MUL, 64'h10000, 64'h10001, 64'h0, 0, 0, 1, 1, 1);
    drain();
`endif

    // 8-bit instance.
    issue(1, "add8_carry", OP_ADD, 64'hFF, 64'h01, 64'h00, 1, 0, 1, 1, 1);
    issue(1, "add8_ovf",   OP_ADD, 64'h7F, 64'h01, 64'h80, 0, 1, 0, 1, 1);
    issue(1, "sra8",       OP_SRA, 64'h80, 64'h09, 64'hC0, 0, 0, 0, 1, 1);
    issue(1, "sub8_neg",   OP_SUB, 64'h03, 64'h05, 64'hFE, 0, 0, 0, 1, 1);
`ifdef ALU_MC_MUL_EN
    issue(1, "mul8",       OP_MUL, 64'h10, 64'h11, 64'h10, 0, 0, 0, 9, 1);
`else
    issue(1, "op0011_8",   OP_MUL, 64'h10, 64'h11, 64'h00, 0, 0, 1, 1, 1);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
